// File: rtl/cu_pkg.sv
// Shared encodings for the accumulator-processor control unit: opcodes, states, Asel codes.
// Pure definitions; no logic, latency or flow control.
package cu_pkg;

    localparam int CU_STATE_W = 4;

    localparam logic [2:0] OP_LOAD  = 3'b000;
    localparam logic [2:0] OP_STORE = 3'b001;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_SUB   = 3'b011;
    localparam logic [2:0] OP_INPUT = 3'b100;
    localparam logic [2:0] OP_JZ    = 3'b101;
    localparam logic [2:0] OP_JPOS  = 3'b110;
    localparam logic [2:0] OP_HALT  = 3'b111;

    // Execute states are {1'b1, opcode} so DECODE is a straight concatenation.
    localparam logic [CU_STATE_W-1:0] S_START  = 4'h0;
    localparam logic [CU_STATE_W-1:0] S_FETCH  = 4'h1;
    localparam logic [CU_STATE_W-1:0] S_DECODE = 4'h2;
    localparam logic [CU_STATE_W-1:0] S_LOAD   = 4'h8;
    localparam logic [CU_STATE_W-1:0] S_STORE  = 4'h9;
    localparam logic [CU_STATE_W-1:0] S_ADD    = 4'hA;
    localparam logic [CU_STATE_W-1:0] S_SUB    = 4'hB;
    localparam logic [CU_STATE_W-1:0] S_INPUT  = 4'hC;
    localparam logic [CU_STATE_W-1:0] S_JZ     = 4'hD;
    localparam logic [CU_STATE_W-1:0] S_JPOS   = 4'hE;
    localparam logic [CU_STATE_W-1:0] S_HALT   = 4'hF;

    localparam logic [1:0] ASEL_ALU = 2'b00;
    localparam logic [1:0] ASEL_IN  = 2'b01;
    localparam logic [1:0] ASEL_RAM = 2'b10;

    function automatic logic [CU_STATE_W-1:0] exec_state(input logic [2:0] op);
        return {1'b1, op};
    endfunction

endpackage

// File: rtl/cu_fsm_if.sv
// Control/status bundle between the control unit (master) and the DP datapath (slave).
// Wires only; no latency or flow control.
interface cu_fsm_if;
    logic [2:0] IR;
    logic       Aeq0;
    logic       Apos;
    logic       IRload;
    logic       JMPmux;
    logic       PCload;
    logic       Meminst;
    logic       MemWr;
    logic [1:0] Asel;
    logic       Aload;
    logic       Sub;

    modport master (
        input  IR, Aeq0, Apos,
        output IRload, JMPmux, PCload, Meminst, MemWr, Asel, Aload, Sub
    );

    modport slave (
        output IR, Aeq0, Apos,
        input  IRload, JMPmux, PCload, Meminst, MemWr, Asel, Aload, Sub
    );
endinterface

// File: rtl/enter_edge.sv
// Synchronizes the asynchronous Enter button and emits a one-cycle pulse per 0->1 transition.
// Latency SYNC_STAGES cycles from the input rise; no backpressure, pulses are never held.
module enter_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic Clock,
    input  logic Reset,
    input  logic Enter,
    output logic pulse
);
    logic [SYNC_STAGES-1:0] sync;
    logic                   sync_d;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            sync   <= '0;
            sync_d <= 1'b0;
        end else begin
            sync   <= {sync[SYNC_STAGES-2:0], Enter};
            sync_d <= sync[SYNC_STAGES-1];
        end
    end

    assign pulse = sync[SYNC_STAGES-1] & ~sync_d;
endmodule

// File: rtl/cu_fsm.sv
// Control unit: START/FETCH/DECODE/execute sequencer driving the DP datapath controls.
// 4 cycles per instruction, INPUT waits for an Enter edge, HALT parks until reset.
module cu_fsm
    import cu_pkg::*;
#(
    parameter int STATE_W     = CU_STATE_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               Enter,
    cu_fsm_if.master           dp,
    output logic               Halt,
    output logic [STATE_W-1:0] State
);
    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_nxt;
    logic               enter_evt;

    enter_edge #(.SYNC_STAGES(SYNC_STAGES)) u_enter_edge (
        .Clock (Clock),
        .Reset (Reset),
        .Enter (Enter),
        .pulse (enter_evt)
    );

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) state <= S_START;
        else        state <= state_nxt;
    end

    // Single-cycle execute states and unused encodings all fall back to START.
    always_comb begin
        state_nxt = S_START;
        case (state)
            S_START:  state_nxt = S_FETCH;
            S_FETCH:  state_nxt = S_DECODE;
            S_DECODE: state_nxt = exec_state(dp.IR);
            S_INPUT:  state_nxt = enter_evt ? S_START : S_INPUT;
            S_HALT:   state_nxt = S_HALT;
            default:  state_nxt = S_START;
        endcase
    end

    always_comb begin
        dp.IRload  = 1'b0;
        dp.JMPmux  = 1'b0;
        dp.PCload  = 1'b0;
        dp.Meminst = 1'b0;
        dp.MemWr   = 1'b0;
        dp.Asel    = ASEL_ALU;
        dp.Aload   = 1'b0;
        dp.Sub     = 1'b0;
        Halt       = 1'b0;
        case (state)
            S_FETCH: begin
                dp.IRload = 1'b1;
                dp.PCload = 1'b1;
            end
            S_DECODE: dp.Meminst = 1'b1;
            S_LOAD: begin
                dp.Aload = 1'b1;
                dp.Asel  = ASEL_RAM;
            end
            S_STORE: begin
                dp.Meminst = 1'b1;
                dp.MemWr   = 1'b1;
            end
            S_ADD: dp.Aload = 1'b1;
            S_SUB: begin
                dp.Aload = 1'b1;
                dp.Sub   = 1'b1;
            end
            S_INPUT: begin
                dp.Asel  = ASEL_IN;
                dp.Aload = enter_evt;
            end
            S_JZ: begin
                dp.JMPmux = 1'b1;
                dp.PCload = dp.Aeq0;
            end
            S_JPOS: begin
                dp.JMPmux = 1'b1;
                dp.PCload = dp.Apos;
            end
            S_HALT: Halt = 1'b1;
            default: ;
        endcase
    end

    assign State = state;
endmodule

// File: tb/tb_cu_fsm.sv
// Directed self-checking bench for cu_fsm with hand-computed expected vectors.
module tb_cu_fsm;
    import cu_pkg::*;

    logic       Clock;
    logic       Reset;
    logic       Enter;
    logic       Halt;
    logic [3:0] State;
    int         vectors;
    int         miscompares;

    cu_fsm_if bus ();

    cu_fsm #(.STATE_W(4), .SYNC_STAGES(2)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .Enter (Enter),
        .dp    (bus),
        .Halt  (Halt),
        .State (State)
    );

    // {IRload, JMPmux, PCload, Meminst, MemWr, Asel[1:0], Aload, Sub, Halt}
    logic [9:0] obs;
    assign obs = {bus.IRload, bus.JMPmux, bus.PCload, bus.Meminst, bus.MemWr,
                  bus.Asel, bus.Aload, bus.Sub, Halt};

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b0; Enter = 1'b0;
        bus.IR = OP_LOAD; bus.Aeq0 = 1'b0; bus.Apos = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (obs !== 10'b0 || State !== S_START) begin
                miscompares++;
                $display("FAIL reset_hold[%0d]: outputs=%b state=%h, want 0/%h", i, obs, State, S_START);
            end
        end
        Reset = 1'b1;
        #1;
        vectors++;
        if (State !== S_START) begin
            miscompares++;
            $display("FAIL reset_release: state=%h, want %h", State, S_START);
        end
        tick();
        vectors++;
        if (State !== S_FETCH || obs !== 10'b1_0_1_0_0_00_0_0_0) begin
            miscompares++;
            $display("FAIL fetch: state=%h outputs=%b, want %h/1010000000", State, obs, S_FETCH);
        end
        tick();
        vectors++;
        if (State !== S_DECODE || obs !== 10'b0_0_0_1_0_00_0_0_0) begin
            miscompares++;
            $display("FAIL decode: state=%h outputs=%b, want %h/0001000000", State, obs, S_DECODE);
        end
        tick();
        tick();
        vectors++;
        if (State !== S_START) begin
            miscompares++;
            $display("FAIL reset_seq_end: state=%h, want %h", State, S_START);
        end
    endtask

    // Waits in INPUT for the Enter event; returns the cycle it appeared on (0 = never).
    task automatic wait_input_event(input string name, output int seen_at);
        seen_at = 0;
        for (int i = 1; i <= 6 && seen_at == 0; i++) begin
            tick();
            if (bus.Aload === 1'b1) seen_at = i;
        end
        vectors++;
        if (seen_at < 2 || seen_at > 3) begin
            miscompares++;
            $display("FAIL %s_latency: event at cycle %0d, want 2..3", name, seen_at);
        end
        vectors++;
        if (seen_at != 0 && obs !== 10'b0_0_0_0_0_01_1_0_0) begin
            miscompares++;
            $display("FAIL %s_complete: outputs=%b, want 0000001100", name, obs);
        end
        if (seen_at != 0) tick();
        vectors++;
        if (State !== S_START || bus.Aload !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_exit: state=%h aload=%b, want %h/0", name, State, bus.Aload, S_START);
        end
    endtask

    task automatic test_input();
        int seen;
        bus.IR = OP_INPUT;
        tick(); tick(); tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors++;
            if (State !== S_INPUT || obs !== 10'b0_0_0_0_0_01_0_0_0) begin
                miscompares++;
                $display("FAIL input_wait[%0d]: state=%h outputs=%b, want %h/0000001000", i, State, obs, S_INPUT);
            end
        end
        Enter = 1'b1;
        wait_input_event("input", seen);
        Enter = 1'b0;
    endtask

    task automatic test_input_held();
        int seen;
        Enter = 1'b1;
        tick(); tick(); tick();
        for (int i = 0; i < 8; i++) begin
            if (i == 5) Enter = 1'b0;
            tick();
            vectors++;
            if (State !== S_INPUT || bus.Aload !== 1'b0) begin
                miscompares++;
                $display("FAIL held_wait[%0d]: state=%h aload=%b, want %h/0", i, State, bus.Aload, S_INPUT);
            end
        end
        Enter = 1'b1;
        wait_input_event("held", seen);
        Enter = 1'b0;
    endtask

    task automatic test_store();
        bus.IR = OP_STORE;
        tick(); tick();
        vectors++;
        if (State !== S_DECODE || obs !== 10'b0_0_0_1_0_00_0_0_0) begin
            miscompares++;
            $display("FAIL store_decode: state=%h outputs=%b, want %h/0001000000", State, obs, S_DECODE);
        end
        tick();
        vectors++;
        if (State !== S_STORE || obs !== 10'b0_0_0_1_1_00_0_0_0) begin
            miscompares++;
            $display("FAIL store_exec: state=%h outputs=%b, want %h/0001100000", State, obs, S_STORE);
        end
        tick();
        vectors++;
        if (State !== S_START) begin
            miscompares++;
            $display("FAIL store_exit: state=%h, want %h", State, S_START);
        end
    endtask

    task automatic test_alu();
        logic [2:0] ops [3];
        logic [3:0] sts [3];
        logic [9:0] exp [3];
        ops = '{OP_LOAD, OP_ADD, OP_SUB};
        sts = '{S_LOAD, S_ADD, S_SUB};
        exp = '{10'b0_0_0_0_0_10_1_0_0, 10'b0_0_0_0_0_00_1_0_0, 10'b0_0_0_0_0_00_1_1_0};
        for (int k = 0; k < 3; k++) begin
            bus.IR = ops[k];
            tick(); tick(); tick();
            vectors++;
            if (State !== sts[k] || obs !== exp[k]) begin
                miscompares++;
                $display("FAIL alu_exec[%0d]: state=%h outputs=%b, want %h/%b", k, State, obs, sts[k], exp[k]);
            end
            tick();
            vectors++;
            if (State !== S_START) begin
                miscompares++;
                $display("FAIL alu_exit[%0d]: state=%h, want %h", k, State, S_START);
            end
        end
    endtask

    task automatic test_branch();
        logic [2:0] ops [4];
        logic       flg [4];
        ops = '{OP_JZ, OP_JZ, OP_JPOS, OP_JPOS};
        flg = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int k = 0; k < 4; k++) begin
            bus.IR = ops[k];
            // The unselected flag is driven opposite so a swapped select is visible.
            if (ops[k] == OP_JZ) begin bus.Aeq0 = flg[k]; bus.Apos = ~flg[k]; end
            else                 begin bus.Apos = flg[k]; bus.Aeq0 = ~flg[k]; end
            tick(); tick(); tick();
            vectors++;
            if (bus.JMPmux !== 1'b1 || bus.PCload !== flg[k] || obs[9] !== 1'b0 || obs[5] !== 1'b0) begin
                miscompares++;
                $display("FAIL branch[%0d]: outputs=%b, want jmpmux=1 pcload=%b", k, obs, flg[k]);
            end
            if (ops[k] == OP_JZ) bus.Aeq0 = ~flg[k];
            else                 bus.Apos = ~flg[k];
            #1;
            vectors++;
            if (bus.PCload !== ~flg[k] || bus.JMPmux !== 1'b1) begin
                miscompares++;
                $display("FAIL branch_toggle[%0d]: pcload=%b jmpmux=%b, want %b/1", k, bus.PCload, bus.JMPmux, ~flg[k]);
            end
            tick();
            vectors++;
            if (State !== S_START) begin
                miscompares++;
                $display("FAIL branch_exit[%0d]: state=%h, want %h", k, State, S_START);
            end
        end
    endtask

    task automatic test_halt();
        bus.IR = OP_HALT;
        tick(); tick(); tick();
        for (int i = 0; i < 20; i++) begin
            Enter = (i % 4 == 1);
            vectors++;
            if (State !== S_HALT || obs !== 10'b0_0_0_0_0_00_0_0_1) begin
                miscompares++;
                $display("FAIL halt[%0d]: state=%h outputs=%b, want %h/0000000001", i, State, obs, S_HALT);
            end
            tick();
        end
        Enter = 1'b0;
        Reset = 1'b0;
        #1;
        Reset = 1'b1;
        vectors++;
        if (State !== S_START || Halt !== 1'b0) begin
            miscompares++;
            $display("FAIL halt_reset: state=%h halt=%b, want %h/0", State, Halt, S_START);
        end
    endtask

    task automatic test_reset_mid();
        bus.IR = OP_STORE;
        tick(); tick(); tick();
        vectors++;
        if (bus.MemWr !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_pre: memwr=%b, want 1", bus.MemWr);
        end
        Reset = 1'b0;
        #1;
        vectors++;
        if (obs !== 10'b0 || State !== S_START) begin
            miscompares++;
            $display("FAIL mid_reset: outputs=%b state=%h, want 0/%h", obs, State, S_START);
        end
        Reset = 1'b1;
        tick();
        vectors++;
        if (State !== S_FETCH || bus.MemWr !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_restart: state=%h memwr=%b, want %h/0", State, bus.MemWr, S_FETCH);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_input();
        test_input_held();
        test_store();
        test_alu();
        test_branch();
        test_halt();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
